// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle game tilt conditioning path.
package doodle_pkg;

    typedef enum logic [1:0] {
        CENTER = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10
    } tilt_state_e;

    // X axis field inside the raw spi_master word
    localparam int ACL_X_MSB = 9;
    localparam int ACL_X_LSB = 5;
    localparam int ACL_W     = 15;

    // |v| for a 5-bit signed value; -16 has no positive twin and clips to 15
    function automatic logic [3:0] sat_mag(input logic signed [4:0] v);
        if (v == 5'sb10000) begin
            return 4'hF;
        end
        return v[4] ? 4'(~v[3:0] + 4'd1) : v[3:0];
    endfunction

endpackage

// File: rtl/tilt_ctrl_if.sv
// Accelerometer input and game-facing tilt outputs bundled for tilt_ctrl.
interface tilt_ctrl_if;
    import doodle_pkg::*;

    logic [ACL_W-1:0] acl_data;
    logic             enable;
    logic             left;
    logic             right;
    logic [3:0]       tilt_intensity;
    logic [3:0]       left_leds;
    logic [3:0]       right_leds;
    logic             sample_tick;

    modport master (
        output acl_data, enable,
        input  left, right, tilt_intensity, left_leds, right_leds, sample_tick
    );

    modport slave (
        input  acl_data, enable,
        output left, right, tilt_intensity, left_leds, right_leds, sample_tick
    );

endinterface

// File: rtl/tilt_avg4.sv
// Four-sample moving average of the X axis with a saturated magnitude.
// The average register already includes the sample shifted in on the tick,
// so avg_o is valid (avg_vld_o high) the cycle right after the tick.
module tilt_avg4
    import doodle_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              clear_i,
    input  logic signed [4:0] x_i,
    output logic signed [4:0] avg_o,
    output logic [3:0]        mag_o,
    output logic              avg_vld_o
);

    logic signed [4:0] s0_q, s1_q, s2_q, s3_q;
    logic signed [4:0] avg_q, avg_d;
    logic              vld_q;
    logic signed [6:0] sum_d;

    // Sum the incoming sample with the three newest held ones; dropping the two
    // LSBs of a two's complement sum is floor division by four
    always_comb begin
        sum_d = 7'(x_i) + 7'(s0_q) + 7'(s1_q) + 7'(s2_q);
        avg_d = sum_d[6:2];
    end

    // Window shift and average capture; disable wipes the history
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            s0_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            avg_q <= '0;
            vld_q <= 1'b0;
        end else if (tick_i) begin
            s0_q  <= x_i;
            s1_q  <= s0_q;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            avg_q <= avg_d;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

    assign avg_o     = avg_q;
    assign mag_o     = sat_mag(avg_q);
    assign avg_vld_o = vld_q;

endmodule

// File: rtl/tilt_ctrl.sv
// Turns the raw accelerometer X reading into debounced left/right commands,
// a tilt intensity and LED patterns for the doodle game.
module tilt_ctrl
    import doodle_pkg::*;
#(
    parameter int SAMPLE_DIV = 16,
    parameter int ENTER_TH   = 2,
    parameter int EXIT_TH    = 1
)
(
    input  logic        Clk,
    input  logic        Reset,
    tilt_ctrl_if.slave  bus
);

    localparam int              CW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SAMPLE_DIV - 1);
    localparam logic signed [4:0] ENTER_P = 5'(ENTER_TH);
    localparam logic signed [4:0] ENTER_N = 5'(-ENTER_TH);
    localparam logic signed [4:0] EXIT_P  = 5'(EXIT_TH);
    localparam logic signed [4:0] EXIT_N  = 5'(-EXIT_TH);

    logic [CW-1:0]     cnt_q;
    logic              tick;
    logic signed [4:0] avg;
    logic [3:0]        mag;
    logic              avg_vld;

    tilt_state_e state_q, state_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic [3:0]  inten_q, inten_d;
    logic [3:0]  lleds_q, lleds_d;
    logic [3:0]  rleds_q, rleds_d;

    assign tick = (cnt_q == CNT_LAST);

    // Free-running sample divider, keeps counting even while the game is idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    tilt_avg4 u_avg (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .tick_i    (tick),
        .clear_i   (!bus.enable),
        .x_i       (bus.acl_data[ACL_X_MSB:ACL_X_LSB]),
        .avg_o     (avg),
        .mag_o     (mag),
        .avg_vld_o (avg_vld)
    );

    // Hysteresis decision and next output values, evaluated only on fresh averages
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        inten_d = inten_q;
        lleds_d = lleds_q;
        rleds_d = rleds_q;
        if (!bus.enable) begin
            state_d = CENTER;
            left_d  = 1'b0;
            right_d = 1'b0;
            inten_d = '0;
            lleds_d = '0;
            rleds_d = '0;
        end else if (avg_vld) begin
            unique case (state_q)
                CENTER: begin
                    if (avg <= ENTER_N)      state_d = RIGHT;
                    else if (avg >= ENTER_P) state_d = LEFT;
                end
                RIGHT: begin
                    if (avg >= ENTER_P)      state_d = LEFT;
                    else if (avg > EXIT_N)   state_d = CENTER;
                end
                LEFT: begin
                    if (avg <= ENTER_N)      state_d = RIGHT;
                    else if (avg < EXIT_P)   state_d = CENTER;
                end
                default: state_d = CENTER;
            endcase
            left_d  = (state_d == LEFT);
            right_d = (state_d == RIGHT);
            inten_d = mag;
            lleds_d = (state_d == LEFT)  ? mag : 4'd0;
            rleds_d = (state_d == RIGHT) ? mag : 4'd0;
        end
    end

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CENTER;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            inten_q <= '0;
            lleds_q <= '0;
            rleds_q <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            inten_q <= inten_d;
            lleds_q <= lleds_d;
            rleds_q <= rleds_d;
        end
    end

    assign bus.left           = left_q;
    assign bus.right          = right_q;
    assign bus.tilt_intensity = inten_q;
    assign bus.left_leds      = lleds_q;
    assign bus.right_leds     = rleds_q;
    assign bus.sample_tick    = tick;

endmodule
